// File: rtl/regfile_bypass_if.sv
// Operand-fetch port bundle between the ID stage and the bypassing register file.
// Each *_bus is packed {we, waddr, wdata}.
interface regfile_bypass_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = 5
);
    localparam int unsigned BUS_W = 1 + AW + DATA_W;

    logic [BUS_W-1:0]  wb_to_rf_bus;
    logic [BUS_W-1:0]  ex_to_id_bus;
    logic [BUS_W-1:0]  mem_to_id_bus;
    logic              ex_is_load;
    logic              re1;
    logic              re2;
    logic [AW-1:0]     raddr1;
    logic [AW-1:0]     raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              stallreq;

    modport master (
        output wb_to_rf_bus, ex_to_id_bus, mem_to_id_bus, ex_is_load,
               re1, re2, raddr1, raddr2,
        input  rdata1, rdata2, stallreq
    );

    modport slave (
        input  wb_to_rf_bus, ex_to_id_bus, mem_to_id_bus, ex_is_load,
               re1, re2, raddr1, raddr2,
        output rdata1, rdata2, stallreq
    );
endinterface

// File: rtl/regfile_bypass.sv
// Register file with $0 hardwired to zero, combinational EX/MEM/WB operand forwarding
// and load-use stall detection for the ID stage.
module regfile_bypass #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32
) (
    input logic             clk,
    input logic             resetn,
    regfile_bypass_if.slave rf
);
    localparam int unsigned AW = 5;

    logic              wb_we,   ex_we,   mem_we;
    logic [AW-1:0]     wb_waddr, ex_waddr, mem_waddr;
    logic [DATA_W-1:0] wb_wdata, ex_wdata, mem_wdata;

    assign {wb_we,  wb_waddr,  wb_wdata}  = rf.wb_to_rf_bus;
    assign {ex_we,  ex_waddr,  ex_wdata}  = rf.ex_to_id_bus;
    assign {mem_we, mem_waddr, mem_wdata} = rf.mem_to_id_bus;

    // Entry 0 has no storage; reads of $0 are forced to zero below.
    logic [DATA_W-1:0] regs [1:NREG-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we && (wb_waddr != '0)) begin
            regs[wb_waddr] <= wb_wdata;
        end
    end

    // A loading EX instruction has no data yet, so it is skipped and the stall covers it.
    function automatic logic [DATA_W-1:0] resolve(
        input logic [AW-1:0]     raddr,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] val;
        if (raddr == '0)
            val = '0;
        else if (ex_we && (ex_waddr == raddr) && !rf.ex_is_load)
            val = ex_wdata;
        else if (mem_we && (mem_waddr == raddr))
            val = mem_wdata;
        else if (wb_we && (wb_waddr == raddr))
            val = wb_wdata;
        else
            val = stored;
        return val;
    endfunction

    logic [DATA_W-1:0] stored1, stored2;
    logic              use1, use2;

    always_comb begin
        stored1 = '0;
        stored2 = '0;
        if (rf.raddr1 != '0) stored1 = regs[rf.raddr1];
        if (rf.raddr2 != '0) stored2 = regs[rf.raddr2];
        rf.rdata1 = resolve(rf.raddr1, stored1);
        rf.rdata2 = resolve(rf.raddr2, stored2);
    end

    always_comb begin
        use1 = rf.re1 && (rf.raddr1 == ex_waddr);
        use2 = rf.re2 && (rf.raddr2 == ex_waddr);
        rf.stallreq = rf.ex_is_load && ex_we && (ex_waddr != '0) && (use1 || use2);
    end
endmodule

// File: tb/tb_regfile_bypass.sv
// Directed scoreboard bench for regfile_bypass: stimulus pushes expected operands/stall,
// a monitor on the falling edge pops and compares.
module tb_regfile_bypass;
    typedef struct {
        string       name;
        bit          c1;
        logic [31:0] e1;
        bit          c2;
        logic [31:0] e2;
        bit          cs;
        logic        es;
    } exp_t;

    localparam logic [37:0] IDLE = '0;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    regfile_bypass_if #(.DATA_W(32), .AW(5)) rf_if ();

    regfile_bypass #(.DATA_W(32), .NREG(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .rf     (rf_if)
    );

    always #5 clk = ~clk;

    function automatic logic [37:0] bus(input logic we, input logic [4:0] a, input logic [31:0] d);
        return {we, a, d};
    endfunction

    task automatic drive(input logic [37:0] wb, input logic [37:0] ex, input logic [37:0] mem,
                         input logic ld, input logic r1e, input logic [4:0] a1,
                         input logic r2e, input logic [4:0] a2);
        rf_if.wb_to_rf_bus  = wb;
        rf_if.ex_to_id_bus  = ex;
        rf_if.mem_to_id_bus = mem;
        rf_if.ex_is_load    = ld;
        rf_if.re1           = r1e;
        rf_if.raddr1        = a1;
        rf_if.re2           = r2e;
        rf_if.raddr2        = a2;
    endtask

    task automatic expect_out(input string nm, input bit c1, input logic [31:0] e1,
                              input bit c2, input logic [31:0] e2, input bit cs, input logic es);
        exp_t e;
        e.name = nm; e.c1 = c1; e.e1 = e1; e.c2 = c2; e.e2 = e2; e.cs = cs; e.es = es;
        sb.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.c1) cmp({e.name, ".rdata1"}, rf_if.rdata1, e.e1);
                if (e.c2) cmp({e.name, ".rdata2"}, rf_if.rdata2, e.e2);
                if (e.cs) cmp({e.name, ".stallreq"}, {31'b0, rf_if.stallreq}, {31'b0, e.es});
            end
        end
    end

    initial begin : stimulus
        drive(IDLE, IDLE, IDLE, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);

        // Reset: forwarding still works, storage reads zero, WB write is dropped.
        cycle();
        drive(bus(1, 4, 32'h99), bus(1, 3, 32'h55), IDLE, 1'b0, 1'b1, 5'd3, 1'b1, 5'd4);
        expect_out("rst_fwd", 1, 32'h55, 1, 32'h99, 1, 1'b0);
        cycle();
        drive(IDLE, IDLE, IDLE, 1'b0, 1'b1, 5'd5, 1'b1, 5'd31);
        expect_out("rst_zero", 1, 32'h0, 1, 32'h0, 1, 1'b0);
        cycle();
        resetn = 1'b1;
        drive(IDLE, IDLE, IDLE, 1'b0, 1'b1, 5'd4, 1'b0, 5'd0);
        expect_out("rst_wr_dropped", 1, 32'h0, 1, 32'h0, 1, 1'b0);

        // Basic write then read, including same-cycle write-through.
        cycle();
        drive(bus(1, 5, 32'h1234_5678), IDLE, IDLE, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0);
        expect_out("wb_through", 1, 32'h1234_5678, 0, 0, 1, 1'b0);
        cycle();
        drive(IDLE, IDLE, IDLE, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0);
        expect_out("wr_read5", 1, 32'h1234_5678, 0, 0, 1, 1'b0);

        // $0 never stores or forwards, and never stalls.
        cycle();
        drive(bus(1, 0, 32'hFFFF_FFFF), bus(1, 0, 32'hDEAD_BEEF), IDLE, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0);
        expect_out("r0_fwd", 1, 32'h0, 1, 32'h0, 1, 1'b0);
        cycle();
        drive(IDLE, bus(1, 0, 32'hDEAD_BEEF), IDLE, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0);
        expect_out("r0_load", 1, 32'h0, 1, 32'h0, 1, 1'b0);

        // Priority EX > MEM > WB > storage.
        cycle();
        drive(bus(1, 8, 32'hC), bus(1, 8, 32'hA), bus(1, 8, 32'hB), 1'b0, 1'b1, 5'd8, 1'b0, 5'd0);
        expect_out("prio_ex", 1, 32'hA, 0, 0, 1, 1'b0);
        cycle();
        drive(bus(1, 8, 32'hC), IDLE, bus(1, 8, 32'hB), 1'b0, 1'b1, 5'd8, 1'b0, 5'd0);
        expect_out("prio_mem", 1, 32'hB, 0, 0, 1, 1'b0);
        cycle();
        drive(bus(1, 8, 32'hC), IDLE, IDLE, 1'b0, 1'b1, 5'd8, 1'b0, 5'd0);
        expect_out("prio_wb", 1, 32'hC, 0, 0, 1, 1'b0);
        cycle();
        drive(IDLE, IDLE, IDLE, 1'b0, 1'b1, 5'd8, 1'b0, 5'd0);
        expect_out("prio_store", 1, 32'hC, 0, 0, 1, 1'b0);
        cycle();
        drive(bus(0, 8, 32'hF1), bus(0, 8, 32'hEE), bus(0, 8, 32'hDD), 1'b0, 1'b1, 5'd8, 1'b1, 5'd5);
        expect_out("we0_nofwd", 1, 32'hC, 1, 32'h1234_5678, 1, 1'b0);
        cycle();
        drive(IDLE, IDLE, IDLE, 1'b0, 1'b1, 5'd8, 1'b0, 5'd0);
        expect_out("we0_nowrite", 1, 32'hC, 0, 0, 1, 1'b0);

        // Load-use stall detection.
        cycle();
        drive(IDLE, bus(1, 9, 32'h1), IDLE, 1'b1, 1'b0, 5'd0, 1'b1, 5'd9);
        expect_out("ld_use_p2", 0, 0, 0, 0, 1, 1'b1);
        cycle();
        drive(IDLE, bus(1, 9, 32'h1), IDLE, 1'b1, 1'b0, 5'd0, 1'b0, 5'd9);
        expect_out("ld_use_dis", 0, 0, 0, 0, 1, 1'b0);
        cycle();
        drive(IDLE, bus(1, 9, 32'h1), bus(1, 9, 32'h44), 1'b1, 1'b1, 5'd9, 1'b0, 5'd0);
        expect_out("ld_use_p1", 1, 32'h44, 0, 0, 1, 1'b1);
        cycle();
        drive(IDLE, bus(0, 9, 32'h1), IDLE, 1'b1, 1'b1, 5'd9, 1'b1, 5'd9);
        expect_out("ld_we0", 0, 0, 0, 0, 1, 1'b0);
        cycle();
        drive(IDLE, bus(1, 9, 32'h1), IDLE, 1'b1, 1'b1, 5'd10, 1'b1, 5'd11);
        expect_out("ld_other", 0, 0, 0, 0, 1, 1'b0);
        cycle();
        drive(IDLE, IDLE, bus(1, 9, 32'h77), 1'b0, 1'b0, 5'd0, 1'b1, 5'd9);
        expect_out("ld_in_mem", 0, 0, 1, 32'h77, 1, 1'b0);

        // Fill $1..$31 with their index, then reset mid-cycle.
        for (int i = 1; i < 32; i++) begin
            cycle();
            drive(bus(1, 5'(i), 32'(i)), IDLE, IDLE, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        end
        cycle();
        drive(IDLE, IDLE, IDLE, 1'b0, 1'b1, 5'd7, 1'b1, 5'd31);
        expect_out("fill_read", 1, 32'd7, 1, 32'd31, 1, 1'b0);
        cycle();
        drive(IDLE, IDLE, IDLE, 1'b0, 1'b1, 5'd1, 1'b1, 5'd30);
        #1 resetn = 1'b0;
        expect_out("async_rst", 1, 32'h0, 1, 32'h0, 1, 1'b0);
        @(negedge clk);
        #1 resetn = 1'b1;
        cycle();
        drive(bus(1, 31, 32'hCAFE), IDLE, IDLE, 1'b0, 1'b1, 5'd7, 1'b1, 5'd31);
        expect_out("post_rst_wb", 1, 32'h0, 1, 32'hCAFE, 1, 1'b0);
        cycle();
        drive(IDLE, IDLE, IDLE, 1'b0, 1'b1, 5'd30, 1'b1, 5'd31);
        expect_out("post_rst_rd", 1, 32'h0, 1, 32'hCAFE, 1, 1'b0);

        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
